serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//   Bit-serial WIDTH-bit subtractor controller around one full_half_sub slice
//   (a - b - bin per bit, LSB first). Accepts an operand pair via valid/ready,
//   sequences one bit per clock through the slice with a registered borrow, and
//   returns diff/borrow via valid/ready. Trades WIDTH cycles for one slice.
// PARAMETERS
//   WIDTH    8    operand/result width in bits; legal range 2..64
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair a/b/bin valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in for bit 0
//   abort      in   1      synchronous cancel of the current operation
//   out_valid  out  1      diff/bout valid; held until out_ready
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow out of MSB (1 = a < b + bin, unsigned)
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, in_ready=0 while asserted, out_valid=0,
//     diff=0, bout=0, shift regs, borrow reg, bit counter all 0.
//   - in_ready = (state==IDLE) && rst_n; combinational from state.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: on in_valid&&in_ready edge latch a,b into shift regs, borrow<=bin,
//     cnt<=0, go RUN. in_valid while not IDLE is ignored, never queued.
//   - RUN: each edge feed a_sr[0], b_sr[0], borrow into slice; borrow<=slice
//     borrow; shift slice diff into result MSB, shift result right;
//     shift a_sr/b_sr right; cnt<=cnt+1. Counter width $clog2(WIDTH)+1.
//     At cnt==WIDTH-1 (last bit) go DONE; diff<=final result, bout<=slice borrow.
//   - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//   - DONE: out_valid=1; diff/bout stable until out_valid&&out_ready edge, then
//     out_valid<=0, go IDLE. No bypass: next operand accepted one cycle after
//     the result is consumed (throughput 1 op per WIDTH+2 cycles minimum).
//   - diff/bout hold last result after handshake until next op's DONE.
//   - abort=1 on any edge: state<=IDLE, out_valid<=0, cnt<=0; abort has priority
//     over in_valid and out_ready; diff/bout keep their previous values.
//   - rst_n asserted mid-RUN or mid-DONE: operation lost, reset values apply
//     immediately; no result ever presented for it.
//   - Wrap-around: a<b+bin gives two's-complement wrap, bout=1.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined: adds output port `ovf` (1 bit) = signed overflow
//     (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), registered with diff, valid with
//     out_valid, reset 0, held/cleared exactly like bout.
//   Not defined: no ovf port, no related logic; all other behaviour identical.
// TESTING (WIDTH=8)
//   a=0x05,b=0x03,bin=0 -> after 8 clks out_valid=1, diff=0x02, bout=0
//   a=0x00,b=0x01,bin=0 -> diff=0xFF, bout=1; a=0x10,b=0x0F,bin=1 -> 0x00, bout=0
//   out_ready=0 for 5 clks in DONE with in_valid=1 -> diff/bout stable,
//     in_ready=0, no new capture; out_ready=1 -> IDLE, in_ready=1 next clk
//   rst_n=0 at cnt=3 of a=0xAA,b=0x55 -> out_valid=0, diff=0, IDLE; next op
//     a=0x09,b=0x04 -> diff=0x05 after 8 clks
//   abort=1 at cnt=4 -> IDLE next clk, out_valid never rises, diff unchanged
//   SERIAL_SUB_OVF_EN: a=0x80,b=0x01 -> diff=0x7F, ovf=1; a=0x05,b=0x03 -> ovf=0

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtract slice, one bit per clock, LSB first.
// Optional `SERIAL_SUB_OVF_EN adds a registered signed-overflow output `ovf`.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             s_d;
  logic             s_bo;

  // Full-subtract slice: a - b - borrow for the current bit.
  // NOTE: every output gets a value on every path so no latch is inferred.
  always_comb begin
    s_d  = a_sr[0] ^ b_sr[0] ^ borrow;
    s_bo = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  end

  assign in_ready = (state == IDLE) && rst_n;

  // NOTE: sequential state uses non-blocking assignments only; all registers
  // (including the shift registers) are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {s_d, res_sr[WIDTH-1:1]};
          borrow <= s_bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            diff      <= {s_d, res_sr[WIDTH-1:1]};
            bout      <= s_bo;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the slice inputs are the operand MSBs.
            ovf       <= (a_sr[0] != b_sr[0]) && (s_d != a_sr[0]);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus random
// operands compared against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
  logic             exp_ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_diff;
  logic             exp_bout;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: accept, measure latency, check result, stall, consume.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic obin,
                       input int hold);
    int r;
    int cyc;
    logic [7:0] ed;
    logic eb;
`ifdef SERIAL_SUB_OVF_EN
    int sr;
    logic eo;
    sr = int'($signed(oa)) - int'($signed(ob)) - int'(obin);
    eo = (sr < -128) || (sr > 127);
`endif
    r  = int'(oa) - int'(ob) - int'(obin);
    ed = r[7:0];
    eb = (r < 0);

    @(negedge clk);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    @(posedge clk); #1;
    check("accept_in_ready", in_ready, 0);
    check("prev_diff_held", diff, exp_diff);
    check("prev_bout_held", bout, exp_bout);
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);

    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, WIDTH);
    check("diff", diff, ed);
    check("bout", bout, eb);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, eo);
    exp_ovf = eo;
`endif
    exp_diff = ed;
    exp_bout = eb;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_diff", diff, ed);
      check("stall_bout", bout, eb);
      check("stall_in_ready", in_ready, 0);
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_out_valid", out_valid, 0);
    check("consume_in_ready", in_ready, 1);
    check("consume_diff_held", diff, ed);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    exp_diff = '0; exp_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf = 1'b0;
`endif
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed arithmetic cases, including wrap-around and a 5-cycle stall.
    do_op(8'h05, 8'h03, 1'b0, 5);
    do_op(8'h00, 8'h01, 1'b0, 0);
    do_op(8'h10, 8'h0F, 1'b1, 1);
    do_op(8'h80, 8'h01, 1'b0, 0);
    do_op(8'h05, 8'h03, 1'b0, 0);
    do_op(8'h00, 8'hFF, 1'b1, 2);
    do_op(8'hFF, 8'h00, 1'b0, 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    check("midrst_in_ready", in_ready, 0);
    exp_diff = '0; exp_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    check("midrst_idle", in_ready, 1);
    do_op(8'h09, 8'h04, 1'b0, 0);

    // Abort at cnt=4: back to IDLE, no result, diff keeps the old value.
    @(negedge clk);
    a = 8'h3C; b = 8'h11; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    abort = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    check("abort_diff_held", diff, exp_diff);
    check("abort_bout_held", bout, exp_bout);

    // Abort has priority over in_valid in IDLE.
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1; a = 8'h77; b = 8'h22;
    @(posedge clk); #1;
    check("abort_prio_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;

    // Random operands with random stall lengths.
    repeat (20) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
